signed_offset_pipe: RTL and testbench

//  Streaming successor to the 4-bit signed offset converter: per beat, y = x + POS_OFF if x >= 0, else y = x + NEG_OFF.

---
 rtl/signed_offset_pkg.sv | 22 ++
 rtl/signed_offset_pipe_if.sv | 43 ++++
 rtl/offset_core.sv | 53 +++++
 rtl/signed_offset_pipe.sv | 128 ++++++++++++
 tb/tb_signed_offset_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/signed_offset_pkg.sv
// rtl/signed_offset_pkg.sv - shared types and range helpers for signed_offset_pipe
//
// Purpose : beat mode encoding and the signed output range of a W+1 bit result.
// Contents: mode_e      MODE_WRAP = 0, MODE_SAT = 1
//           range_max() largest W+1 bit signed value,  2^W - 1
//           range_min() smallest W+1 bit signed value, -2^W
package signed_offset_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   function automatic int range_max(input int w);
      return (1 << w) - 1;
   endfunction

   function automatic int range_min(input int w);
      return -(1 << w);
   endfunction

endpackage

// File: rtl/signed_offset_pipe_if.sv
// rtl/signed_offset_pipe_if.sv - input/output stream bundle for signed_offset_pipe
//
// Purpose : groups the input stream (in_*) and output stream (out_*) handshakes.
// Signals : in_valid, in_ready, in_x[W-1:0], sat_mode    input beat
//           out_valid, out_ready, out_y[W:0], out_ovf    output beat
// Modports: slave  - the pipe (consumes in_*, produces out_*)
//           master - the environment (produces in_*, consumes out_*)
interface signed_offset_pipe_if #(
   parameter int W = 4
);

   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_x;
   logic                sat_mode;
   logic                out_valid;
   logic                out_ready;
   logic signed [W:0]   out_y;
   logic                out_ovf;

   modport slave (
      input  in_valid,
      input  in_x,
      input  sat_mode,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_y,
      output out_ovf
   );

   modport master (
      output in_valid,
      output in_x,
      output sat_mode,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_y,
      input  out_ovf
   );

endinterface

// File: rtl/offset_core.sv
// rtl/offset_core.sv - combinational signed offset add with wrap/saturate
//
// Purpose : y = x + POS_OFF for x >= 0, y = x + NEG_OFF for x < 0, limited to W+1 bits.
// Ports   : x    in  W    signed sample
//           mode in  1    MODE_WRAP or MODE_SAT
//           y    out W+1  signed result
//           ovf  out 1    true sum lies outside the W+1 bit range
module offset_core
   import signed_offset_pkg::*;
#(
   parameter int W       = 4,
   parameter int POS_OFF = 3,
   parameter int NEG_OFF = -2
) (
   input  logic signed [W-1:0] x,
   input  mode_e               mode,
   output logic signed [W:0]   y,
   output logic                ovf
);

   // W+2 bits holds any W-bit input plus any W+1 bit offset without loss.
   localparam int MAX_I = range_max(W);
   localparam int MIN_I = range_min(W);
   localparam logic signed [W+1:0] MAX_E = MAX_I[W+1:0];
   localparam logic signed [W+1:0] MIN_E = MIN_I[W+1:0];
   localparam logic signed [W+1:0] POS_E = POS_OFF[W+1:0];
   localparam logic signed [W+1:0] NEG_E = NEG_OFF[W+1:0];

   logic signed [W+1:0] x_ext;
   logic signed [W+1:0] off;
   logic signed [W+1:0] sum;
   logic                above;
   logic                below;

   always_comb begin
      x_ext = {{2{x[W-1]}}, x};
      // Zero has a clear sign bit, so it takes the non-negative offset.
      off   = x[W-1] ? NEG_E : POS_E;
      sum   = x_ext + off;
      above = (sum > MAX_E);
      below = (sum < MIN_E);
      ovf   = above | below;
      y     = sum[W:0];
      if (mode == MODE_SAT) begin
         if (above) begin
            y = MAX_E[W:0];
         end else if (below) begin
            y = MIN_E[W:0];
         end
      end
   end

endmodule

// File: rtl/signed_offset_pipe.sv
// rtl/signed_offset_pipe.sv - 2-stage valid/ready signed offset pipeline with statistics
//
// Purpose : streams samples through offset_core with one beat/cycle throughput and
//           counts output transfers and overflowed output transfers.
// Ports   : clk        in   1      rising-edge clock
//           rst_n      in   1      asynchronous reset, active low
//           bus        slave       in_valid/in_ready/in_x/sat_mode, out_valid/out_ready/out_y/out_ovf
//           clr        in   1      synchronous clear of beat_cnt, ovf_cnt, ovf_sticky
//           beat_cnt   out  CNT_W  output transfers, wraps
//           ovf_cnt    out  CNT_W  overflowed output transfers, saturates at all-ones
//           ovf_sticky out  1      any overflowed output transfer since reset/clr
module signed_offset_pipe
   import signed_offset_pkg::*;
#(
   parameter int W       = 4,
   parameter int POS_OFF = 3,
   parameter int NEG_OFF = -2,
   parameter int CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   signed_offset_pipe_if.slave   bus,
   input  logic                  clr,
   output logic [CNT_W-1:0]      beat_cnt,
   output logic [CNT_W-1:0]      ovf_cnt,
   output logic                  ovf_sticky
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Stage 1: raw sample and its mode.
   logic                s1_valid;
   logic signed [W-1:0] s1_x;
   mode_e               s1_mode;

   // Stage 2: finished result, drives the output stream.
   logic                s2_valid;
   logic signed [W:0]   s2_y;
   logic                s2_ovf;

   logic                s2_ready;
   logic                in_xfer;
   logic                s1_adv;
   logic                out_xfer;

   logic signed [W:0]   core_y;
   logic                core_ovf;

   // A stage can load whenever it is empty or its content leaves this edge,
   // so a full pipe with out_ready high still moves one beat per cycle.
   assign s2_ready     = !s2_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_ready;

   assign in_xfer  = bus.in_valid && bus.in_ready;
   assign s1_adv   = s1_valid && s2_ready;
   assign out_xfer = s2_valid && bus.out_ready;

   assign bus.out_valid = s2_valid;
   assign bus.out_y     = s2_y;
   assign bus.out_ovf   = s2_ovf;

   offset_core #(
      .W       (W),
      .POS_OFF (POS_OFF),
      .NEG_OFF (NEG_OFF)
   ) u_core (
      .x    (s1_x),
      .mode (s1_mode),
      .y    (core_y),
      .ovf  (core_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_mode  <= MODE_WRAP;
      end else begin
         if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
         end
         if (in_xfer) begin
            s1_x    <= bus.in_x;
            s1_mode <= mode_e'(bus.sat_mode);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_y     <= '0;
         s2_ovf   <= 1'b0;
      end else begin
         if (s2_ready) begin
            s2_valid <= s1_valid;
         end
         // Data only moves with a real beat, keeping out_y stable while stalled.
         if (s1_adv) begin
            s2_y   <= core_y;
            s2_ovf <= core_ovf;
         end
      end
   end

   // clr wins over the old totals but not over a beat leaving on the same edge:
   // that beat becomes the first one counted after the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt   <= '0;
         ovf_cnt    <= '0;
         ovf_sticky <= 1'b0;
      end else if (clr) begin
         beat_cnt   <= out_xfer ? CNT_ONE : '0;
         ovf_cnt    <= (out_xfer && s2_ovf) ? CNT_ONE : '0;
         ovf_sticky <= out_xfer && s2_ovf;
      end else if (out_xfer) begin
         beat_cnt <= beat_cnt + CNT_ONE;
         if (s2_ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_ONE;
         end
         if (s2_ovf) begin
            ovf_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_signed_offset_pipe.sv
// tb/tb_signed_offset_pipe.sv - self-checking bench for signed_offset_pipe
module tb_signed_offset_pipe;

   localparam int W     = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                in_valid = 1'b0;
   logic signed [W-1:0] in_x = '0;
   logic                sat_mode = 1'b0;
   logic                out_ready = 1'b0;
   logic                clr = 1'b0;

   signed_offset_pipe_if #(.W(W)) bus_a ();
   signed_offset_pipe_if #(.W(W)) bus_b ();

   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_x      = in_x;
   assign bus_a.sat_mode  = sat_mode;
   assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.in_x      = in_x;
   assign bus_b.sat_mode  = sat_mode;
   assign bus_b.out_ready = out_ready;

   logic [CNT_W-1:0] beat_a, ovfc_a, beat_b, ovfc_b;
   logic             sticky_a, sticky_b;

   signed_offset_pipe #(.W(W), .POS_OFF(3), .NEG_OFF(-2), .CNT_W(CNT_W)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus_a),
      .clr        (clr),
      .beat_cnt   (beat_a),
      .ovf_cnt    (ovfc_a),
      .ovf_sticky (sticky_a)
   );

   signed_offset_pipe #(.W(W), .POS_OFF(12), .NEG_OFF(-2), .CNT_W(CNT_W)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus_b),
      .clr        (clr),
      .beat_cnt   (beat_b),
      .ovf_cnt    (ovfc_b),
      .ovf_sticky (sticky_b)
   );

   logic              o_valid [2];
   logic              i_ready [2];
   logic signed [W:0] o_y     [2];
   logic              o_ovf   [2];
   logic [CNT_W-1:0]  o_beat  [2];
   logic [CNT_W-1:0]  o_ovfc  [2];
   logic              o_stk   [2];

   assign o_valid[0] = bus_a.out_valid;
   assign o_valid[1] = bus_b.out_valid;
   assign i_ready[0] = bus_a.in_ready;
   assign i_ready[1] = bus_b.in_ready;
   assign o_y[0]     = bus_a.out_y;
   assign o_y[1]     = bus_b.out_y;
   assign o_ovf[0]   = bus_a.out_ovf;
   assign o_ovf[1]   = bus_b.out_ovf;
   assign o_beat[0]  = beat_a;
   assign o_beat[1]  = beat_b;
   assign o_ovfc[0]  = ovfc_a;
   assign o_ovfc[1]  = ovfc_b;
   assign o_stk[0]   = sticky_a;
   assign o_stk[1]   = sticky_b;

   typedef struct {
      int y;
      bit ovf;
      int acc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   m_beat  [2];
   int   m_ovfc  [2];
   bit   m_stk   [2];
   bit   held    [2];
   int   held_y  [2];
   bit   held_ovf[2];
   int   pos_off [2];
   int   edge_n;
   bit   check_lat;
   bit   check_tp;
   int   n_acc;
   bit   saw_stall;
   int   n_tests;
   int   n_fail;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Plain-integer reference: real sum, then fold into [-2^W, 2^W-1].
   function automatic void ref_model(input int x, input int pos, input bit sat,
                                     output int y, output bit ovf);
      int s;
      int hi;
      int lo;
      hi  = (1 << W) - 1;
      lo  = -(1 << W);
      s   = x + ((x >= 0) ? pos : -2);
      ovf = (s > hi) || (s < lo);
      if (sat) begin
         y = (s > hi) ? hi : ((s < lo) ? lo : s);
      end else begin
         y = s;
         while (y > hi) y -= (1 << (W + 1));
         while (y < lo) y += (1 << (W + 1));
      end
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
         m_beat[d] = 0;
         m_ovfc[d] = 0;
         m_stk[d]  = 1'b0;
         held[d]   = 1'b0;
      end
   endtask

   // One clock: inputs were set at the preceding negedge; sample, predict, advance.
   task automatic cycle();
      exp_t e;
      int   y;
      bit   ovf;
      bit   xfer;
      int   qs;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (held[d]) begin
            chk($sformatf("hold_valid[%0d]", d), o_valid[d], 1);
            chk($sformatf("hold_y[%0d]", d), o_y[d], held_y[d]);
            chk($sformatf("hold_ovf[%0d]", d), o_ovf[d], held_ovf[d]);
         end
         held[d]     = o_valid[d] && !out_ready;
         held_y[d]   = o_y[d];
         held_ovf[d] = o_ovf[d];
         if (check_tp) chk($sformatf("in_ready[%0d]", d), i_ready[d], 1);
         if (d == 0 && in_valid && !i_ready[0]) saw_stall = 1'b1;
         xfer = o_valid[d] && out_ready;
         e    = '{y: 0, ovf: 1'b0, acc: 0};
         if (xfer) begin
            qs = (d == 0) ? q0.size() : q1.size();
            chk($sformatf("ghost[%0d]", d), qs > 0, 1);
            if (qs > 0) begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("out_y[%0d]", d), o_y[d], e.y);
               chk($sformatf("out_ovf[%0d]", d), o_ovf[d], e.ovf);
               if (check_lat) chk($sformatf("latency[%0d]", d), edge_n + 1 - e.acc, 2);
            end
         end
         if (clr) begin
            m_beat[d] = xfer ? 1 : 0;
            m_ovfc[d] = (xfer && e.ovf) ? 1 : 0;
            m_stk[d]  = xfer && e.ovf;
         end else if (xfer) begin
            m_beat[d] = (m_beat[d] + 1) % (1 << CNT_W);
            if (e.ovf && m_ovfc[d] < (1 << CNT_W) - 1) m_ovfc[d]++;
            if (e.ovf) m_stk[d] = 1'b1;
         end
         if (in_valid && i_ready[d]) begin
            ref_model(in_x, pos_off[d], sat_mode, y, ovf);
            if (d == 0) begin
               q0.push_back('{y: y, ovf: ovf, acc: edge_n + 1});
               n_acc++;
            end else begin
               q1.push_back('{y: y, ovf: ovf, acc: edge_n + 1});
            end
         end
      end
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("beat_cnt[%0d]", d), o_beat[d], m_beat[d]);
         chk($sformatf("ovf_cnt[%0d]", d), o_ovfc[d], m_ovfc[d]);
         chk($sformatf("ovf_sticky[%0d]", d), o_stk[d], m_stk[d]);
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12 && (q0.size() > 0 || q1.size() > 0); i++) cycle();
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
   endtask

   task automatic clear_stats();
      in_valid = 1'b0;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
   endtask

   initial begin
      int  found;
      n_tests   = 0;
      n_fail    = 0;
      edge_n    = 0;
      check_lat = 1'b0;
      check_tp  = 1'b0;
      pos_off[0] = 3;
      pos_off[1] = 12;
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_out_valid[%0d]", d), o_valid[d], 0);
         chk($sformatf("rst_out_y[%0d]", d), o_y[d], 0);
         chk($sformatf("rst_out_ovf[%0d]", d), o_ovf[d], 0);
         chk($sformatf("rst_beat[%0d]", d), o_beat[d], 0);
         chk($sformatf("rst_ovfc[%0d]", d), o_ovfc[d], 0);
         chk($sformatf("rst_sticky[%0d]", d), o_stk[d], 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // 1. Exhaustive sweep, wrap mode, no stall
      check_lat = 1'b1;
      check_tp  = 1'b1;
      out_ready = 1'b1;
      sat_mode  = 1'b0;
      for (int x = -8; x <= 7; x++) begin
         in_valid = 1'b1;
         in_x     = 4'(x);
         cycle();
      end
      check_tp = 1'b0;
      drain();
      chk("sweep_beat_a", beat_a, 16);
      chk("sweep_ovfc_a", ovfc_a, 0);

      // 2. Overflow in wrap then saturate (POS_OFF = 12 on dut_b)
      clear_stats();
      in_valid = 1'b1;
      in_x     = 4'sd7;
      sat_mode = 1'b0;
      cycle();
      sat_mode = 1'b1;
      cycle();
      drain();
      chk("ovf_pair_ovfc_b", ovfc_b, 2);
      chk("ovf_pair_sticky_b", sticky_b, 1);

      // 3. Backpressure: out_ready low for cycles 3..8
      check_lat = 1'b0;
      clear_stats();
      n_acc     = 0;
      saw_stall = 1'b0;
      for (int c = 1; c <= 40 && n_acc < 6; c++) begin
         out_ready = !(c >= 3 && c <= 8);
         in_valid  = 1'b1;
         in_x      = 4'($urandom_range(0, 15));
         sat_mode  = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("bp_accepted", n_acc, 6);
      chk("bp_in_ready_dropped", saw_stall, 1);
      drain();
      chk("bp_beat_a", beat_a, 6);

      // 4. Reset with two beats in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      repeat (2) begin
         in_x = 4'($urandom_range(0, 15));
         cycle();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("midrst_out_valid[%0d]", d), o_valid[d], 0);
         chk($sformatf("midrst_beat[%0d]", d), o_beat[d], 0);
         chk($sformatf("midrst_ovfc[%0d]", d), o_ovfc[d], 0);
         chk($sformatf("midrst_sticky[%0d]", d), o_stk[d], 0);
      end
      model_reset();
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      check_lat = 1'b1;
      cycle();
      in_valid = 1'b1;
      in_x     = -4'sd3;
      cycle();
      drain();
      chk("post_rst_beat_a", beat_a, 1);

      // 5. clr on the same edge as an overflowed transfer
      clear_stats();
      in_valid = 1'b1;
      in_x     = 4'sd7;
      sat_mode = 1'b0;
      cycle();
      in_valid = 1'b0;
      found    = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (o_valid[1]) begin
            found = 1;
            break;
         end
         cycle();
      end
      chk("clr_wait_out_valid", found, 1);
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      chk("clr_xfer_beat_b", beat_b, 1);
      chk("clr_xfer_ovfc_b", ovfc_b, 1);
      chk("clr_xfer_sticky_b", sticky_b, 1);
      clear_stats();
      chk("clr_idle_beat_b", beat_b, 0);
      chk("clr_idle_ovfc_b", ovfc_b, 0);
      chk("clr_idle_sticky_b", sticky_b, 0);

      // 6. 300 overflowing beats with a toggling consumer
      check_lat = 1'b0;
      n_acc     = 0;
      for (int c = 0; c < 2000 && n_acc < 300; c++) begin
         in_valid  = 1'b1;
         in_x      = 4'($urandom_range(4, 7));
         sat_mode  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      chk("sat_accepted", n_acc, 300);
      drain();
      chk("sat_ovfc_b", ovfc_b, 255);
      chk("sat_beat_b", beat_b, 44);
      chk("sat_beat_a", beat_a, 44);

      // 7. Fully random traffic
      for (int c = 0; c < 300; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_x      = 4'($urandom_range(0, 15));
         sat_mode  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         clr       = ($urandom_range(0, 31) == 0);
         cycle();
      end
      clr = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
